riscv_fetch_unit: RTL

Instruction fetch stage for `RISCVCPU`, sitting between the 1024-word instruction memory and the decode stage. It holds the PC and issues one word read per cycle to a synchronous instruction memory with a 1-cycle read latency. Returned words are buffered with their PC in a small prefetch FIFO and handed to decode over a valid/ready handshake. On a redirect (branch/jump resolved downstream), it flushes the buffer, discards any in-flight read, and restarts at the new PC.

---
 rtl/riscv_fetch_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// riscv_fetch_unit
//
// Instruction fetch stage. It holds the fetch PC and issues at most one word
// read per cycle to a synchronous instruction memory with one cycle of read
// latency. Returned words are stored with their byte PC in a small prefetch
// FIFO and handed to decode over a valid/ready handshake. A redirect flushes
// the FIFO, drops any in-flight read and restarts fetch at the new PC.
//
// Ports
//   clock          : single clock, all state updates on the rising edge
//   reset          : synchronous, active-high reset
//   imem_req       : read request this cycle
//   imem_addr      : word address, fetch_pc[ADDR_WIDTH+1:2]
//   imem_rdata     : read data, valid the cycle after imem_req
//   redirect_valid : restart fetch at redirect_pc
//   redirect_pc    : new byte PC (bits [1:0] forced to zero)
//   out_valid      : FIFO head is valid
//   out_ready      : decode accepts the head this cycle
//   out_instr      : head instruction word
//   out_pc         : head byte PC
// -----------------------------------------------------------------------------
module riscv_fetch_unit #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc
);

    // Pointer, count and occupancy widths. Occupancy (count + inflight) can
    // reach DEPTH+1 transiently in the arithmetic, so it gets one extra bit.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);

    // Architectural state
    logic [31:0]   fetch_pc_q,    fetch_pc_d;
    logic          inflight_q,    inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] rd_ptr_q,      rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,      wr_ptr_d;
    logic [CW-1:0] count_q,       count_d;
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_pc_d    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];

    // Per-cycle control
    logic          pop_s;
    logic          push_s;
    logic          issue_s;
    logic [OW-1:0] occupancy_s;
    logic          unused_pc_bits_s;

    // The low two redirect bits are ignored by definition.
    assign unused_pc_bits_s = ^redirect_pc[1:0];

    // Outputs driven straight from registered state.
    assign out_valid = (count_q != {CW{1'b0}});
    assign out_pc    = fifo_pc_q[rd_ptr_q];
    assign out_instr = fifo_instr_q[rd_ptr_q];
    assign imem_addr = fetch_pc_q[ADDR_WIDTH+1:2];
    assign imem_req  = issue_s;

    // Handshake, response push and issue decision. Issue reserves a FIFO slot
    // for every read in flight, so a push can never find the FIFO full. The
    // pop term is the only combinational path from out_ready to an output.
    always_comb begin
        pop_s       = out_valid & out_ready;
        push_s      = inflight_q & ~redirect_valid;
        occupancy_s = OW'(count_q) + OW'(inflight_q) - OW'(pop_s);
        issue_s     = ~reset & ~redirect_valid & (occupancy_s < DEPTH_OCC);
    end

    // Fetch PC and in-flight tracking. A redirect discards the response
    // arriving this cycle and suppresses issue; otherwise an issue advances
    // the PC and marks the new read in flight.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
        end else if (issue_s) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end else begin
            fetch_pc_d    = fetch_pc_q;
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
        end
    end

    // Prefetch FIFO next state. A redirect empties it; a handshake in the
    // same cycle has already delivered the head, so only count and pointers
    // need clearing. Stale storage is harmless while count is zero.
    always_comb begin
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        if (redirect_valid) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d               = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // State registers with synchronous reset; reset also drops any response
    // that would arrive in the following cycle by clearing inflight.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            rd_ptr_q      <= {PW{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= 32'h0000_0000;
                fifo_instr_q[i] <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= fifo_pc_d[i];
                fifo_instr_q[i] <= fifo_instr_d[i];
            end
        end
    end

endmodule
